weight_pattern_enum: RTL and testbench
======================================

Name: weight_pattern_enum

Overview:
- Sequential inverse of the 5-input weight-count (rd53-style) benchmark.
- Given a requested Hamming weight k, it emits, in ascending numeric order, every N-bit pattern whose popcount equals k.
- The last pattern of the sequence is flagged.
- Used as a stimulus source that drives weight-class vectors into the combinational weight counters under evaluation.

Parameters:
- N, 5, pattern width (number of counter inputs).
- W, 3, weight field width; must satisfy 2^W > N.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block idle and accepting a request.
- req_weight  input  W  requested weight k, sampled on the request handshake.
- out_valid  output  1  out_pattern/out_last valid.
- out_ready  input  1  downstream accepts the pattern.
- out_pattern  output  N  pattern with popcount k.
- out_last  output  1  current pattern is the final one for this request.
- err  output  1  one-cycle pulse when the requested weight is illegal.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, cnt=0, out_valid=0, out_pattern=0, out_last=0, err=0.
  - req_ready=1 in the first cycle after release.
- State IDLE:
  - req_ready=1.
  - Request handshake is req_valid&req_ready at a clock edge; on it, latch k=req_weight.
  - If k>N: err=1 for exactly one cycle, state stays IDLE, no patterns emitted.
  - Else: cnt<=0, state<=SCAN.
- State SCAN:
  - req_ready=0.
  - Each cycle examine candidate cnt.
  - If popcount(cnt)==k:
    - out_pattern<=cnt.
    - out_last<=(cnt == ((2^k-1) << (N-k))), i.e. the top k bits set. For k=0 the last pattern is 0.
    - out_valid<=1, state<=EMIT.
  - Else cnt<=cnt+1.
  - One candidate per cycle; no skipping.
  - cnt is N+1 bits wide and cannot wrap, because the last match is always found before reaching 2^N.
- State EMIT:
  - out_valid=1.
  - out_pattern and out_last are held stable while out_ready=0.
  - On out_valid&out_ready:
    - If out_last: out_valid<=0, state<=IDLE; req_ready=1 the next cycle.
    - Else: out_valid<=0, cnt<=cnt+1, state<=SCAN.
  - out_valid is therefore low for at least one cycle between consecutive patterns.
- Latency:
  - Request accepted at edge T.
  - First out_valid rises at edge T+1+(2^k-1)+1, i.e. T+2 for k=0 and T+9 for k=3.
- Pattern counts per request are C(N,k). For N=5: k=0..5 gives 1,5,10,10,5,1.
- Boundary conditions:
  - req_valid while busy is ignored (req_ready=0) and is not queued.
  - k=N emits a single pattern 2^N-1 with out_last=1.
  - out_ready held high permanently gives a throughput of 1 pattern per (gap+2) cycles.
  - The err pulse and out_valid are never high together.
- Reset mid-operation:
  - Immediate abort: out_valid drops asynchronously, and the pending pattern is lost.
  - After release the block is IDLE.
- No combinational path from out_ready or req_valid to any output.

Test Plan:
- Reset, then req_weight=2 with out_ready=1:
  - Patterns 0x03,0x05,0x06,0x09,0x0A,0x0C,0x11,0x12,0x14,0x18 in that order.
  - out_last=1 only on 0x18.
  - req_ready returns high the cycle after the final handshake.
- req_weight=0, then req_weight=5:
  - Single pattern 0x00 with out_last=1, first out_valid 2 cycles after accept.
  - Then a single pattern 0x1F with out_last=1.
- req_weight=6 or 7:
  - err high for exactly one cycle, out_valid stays 0.
  - req_ready stays 1 and the next legal request is accepted normally.
- req_weight=3 with out_ready randomly throttled (about 50%):
  - out_pattern and out_last stay stable during stalls.
  - Exactly 10 patterns, each popcount 3, strictly ascending, last 0x1C.
- req_valid pulsed repeatedly during a weight-1 sequence:
  - Extra requests ignored; exactly 5 patterns 0x01,0x02,0x04,0x08,0x10.
- Assert rst_n low while in EMIT during a weight-4 request:
  - out_valid=0 immediately.
  - After release, req_ready=1 and a new weight-4 request yields 0x0F,0x17,0x1B,0x1D,0x1E.

Source files
------------

// File: rtl/weight_pattern_enum.sv
// Enumerates, in ascending order, every N-bit pattern whose popcount equals a
// requested weight k, one pattern per handshake, flagging the final one.
module weight_pattern_enum #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_weight,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pattern,
    output logic         out_last,
    output logic         err
);

    localparam logic [W-1:0] N_W = W'(N);
    localparam logic [N:0]   CNT_ONE = (N+1)'(1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    state_t       state_q, state_d;
    logic [N:0]   cnt_q, cnt_d;
    logic [N-1:0] cand_q, cand_d;
    logic         cand_vld_q, cand_vld_d;
    logic [W-1:0] k_q, k_d;
    logic         out_valid_q, out_valid_d;
    logic [N-1:0] out_pattern_q, out_pattern_d;
    logic         out_last_q, out_last_d;
    logic         err_q, err_d;

    logic [W-1:0] cand_weight;
    logic [N-1:0] last_pat;
    logic         hit;
    logic         weight_bad;

    // The candidate is registered before its popcount is compared, so each
    // match costs one pipeline cycle; cnt_q always holds the next candidate.
    always_comb begin
        cand_weight = '0;
        for (int i = 0; i < N; i++) begin
            cand_weight = cand_weight + W'(cand_q[i]);
        end
        last_pat = '0;
        for (int i = 0; i < N; i++) begin
            last_pat[i] = (i >= N - int'(k_q));
        end
        hit        = cand_vld_q && (cand_weight == k_q);
        weight_bad = (req_weight > N_W);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            cand_vld_q    <= 1'b0;
            k_q           <= '0;
            out_valid_q   <= 1'b0;
            out_pattern_q <= '0;
            out_last_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            cand_vld_q    <= cand_vld_d;
            k_q           <= k_d;
            out_valid_q   <= out_valid_d;
            out_pattern_q <= out_pattern_d;
            out_last_q    <= out_last_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid && !weight_bad) state_d = SCAN;
            SCAN: if (hit) state_d = EMIT;
            EMIT: if (out_ready) state_d = out_last_q ? IDLE : SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        cand_d        = cand_q;
        cand_vld_d    = cand_vld_q;
        k_d           = k_q;
        out_valid_d   = out_valid_q;
        out_pattern_d = out_pattern_q;
        out_last_d    = out_last_q;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    k_d = req_weight;
                    if (weight_bad) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d      = '0;
                        cand_vld_d = 1'b0;
                    end
                end
            end
            SCAN: begin
                if (hit) begin
                    out_pattern_d = cand_q;
                    out_last_d    = (cand_q == last_pat);
                    out_valid_d   = 1'b1;
                    cand_vld_d    = 1'b0;
                end else begin
                    cand_d     = cnt_q[N-1:0];
                    cand_vld_d = 1'b1;
                    cnt_d      = cnt_q + CNT_ONE;
                end
            end
            EMIT: begin
                if (out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE);
        out_valid   = out_valid_q;
        out_pattern = out_pattern_q;
        out_last    = out_last_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_weight_pattern_enum.sv
// Directed bench for weight_pattern_enum: stimulus and checks happen on the
// falling clock edge, expectations are hand-computed pattern tables.
module tb_weight_pattern_enum;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_weight;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_pattern;
    logic       out_last;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [4:0] exp_w2 [10] = '{5'h03, 5'h05, 5'h06, 5'h09, 5'h0A, 5'h0C, 5'h11, 5'h12, 5'h14, 5'h18};
    logic [4:0] exp_w3 [10] = '{5'h07, 5'h0B, 5'h0D, 5'h0E, 5'h13, 5'h15, 5'h16, 5'h19, 5'h1A, 5'h1C};
    logic [4:0] exp_w1 [5]  = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
    logic [4:0] exp_w4 [5]  = '{5'h0F, 5'h17, 5'h1B, 5'h1D, 5'h1E};

    weight_pattern_enum #(.N(5), .W(3)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_weight(req_weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pattern(out_pattern),
        .out_last(out_last),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rv, input logic [2:0] w, input logic ordy);
        req_valid  = rv;
        req_weight = w;
        out_ready  = ordy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic waitValid(output bit got);
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic collectPattern(input string tag, input logic [4:0] exp_pat, input logic exp_last);
        bit got;
        waitValid(got);
        checkOutput({tag, " valid"}, 32'(got), 1);
        checkOutput({tag, " pattern"}, 32'(out_pattern), 32'(exp_pat));
        checkOutput({tag, " last"}, 32'(out_last), 32'(exp_last));
        checkOutput({tag, " no err"}, 32'(err), 0);
        @(negedge clk);
    endtask

    initial begin
        bit         got;
        bit         done;
        bit         stalled;
        int         idx;
        logic [4:0] held_pat;
        logic       held_last;
        logic [4:0] prev_pat;

        applyStimulus(1'b0, 3'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst req_ready", 32'(req_ready), 1);
        checkOutput("rst out_valid", 32'(out_valid), 0);
        checkOutput("rst out_pattern", 32'(out_pattern), 0);
        checkOutput("rst out_last", 32'(out_last), 0);
        checkOutput("rst err", 32'(err), 0);

        $display("[TB] weight 2, out_ready high");
        applyStimulus(1'b1, 3'd2, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("w2 busy req_ready", 32'(req_ready), 0);
        for (int i = 0; i < 10; i++) begin
            collectPattern("w2", exp_w2[i], i == 9);
        end
        checkOutput("w2 idle req_ready", 32'(req_ready), 1);
        checkOutput("w2 idle out_valid", 32'(out_valid), 0);

        $display("[TB] weight 0 latency, then weight 5");
        applyStimulus(1'b1, 3'd0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("w0 T+1 out_valid", 32'(out_valid), 0);
        @(negedge clk);
        checkOutput("w0 T+2 out_valid", 32'(out_valid), 0);
        @(negedge clk);
        checkOutput("w0 out_valid", 32'(out_valid), 1);
        checkOutput("w0 pattern", 32'(out_pattern), 0);
        checkOutput("w0 last", 32'(out_last), 1);
        @(negedge clk);
        checkOutput("w0 idle req_ready", 32'(req_ready), 1);
        applyStimulus(1'b1, 3'd5, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        collectPattern("w5", 5'h1F, 1'b1);
        checkOutput("w5 idle req_ready", 32'(req_ready), 1);
        checkOutput("w5 idle out_valid", 32'(out_valid), 0);

        $display("[TB] illegal weights 6 and 7");
        for (int w = 6; w <= 7; w++) begin
            applyStimulus(1'b1, 3'(w), 1'b1);
            @(negedge clk);
            req_valid = 1'b0;
            checkOutput("bad err pulse", 32'(err), 1);
            checkOutput("bad out_valid", 32'(out_valid), 0);
            checkOutput("bad req_ready", 32'(req_ready), 1);
            @(negedge clk);
            checkOutput("bad err cleared", 32'(err), 0);
            checkOutput("bad out_valid later", 32'(out_valid), 0);
        end

        $display("[TB] weight 1 with req_valid pulsing");
        applyStimulus(1'b1, 3'd1, 1'b1);
        @(negedge clk);
        idx = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (out_valid === 1'b1) begin
                if (idx > 4) begin
                    checkOutput("w1 overrun", 32'(idx), 4);
                    done = 1'b1;
                end else begin
                    checkOutput("w1 pattern", 32'(out_pattern), 32'(exp_w1[idx]));
                    checkOutput("w1 last", 32'(out_last), 32'(idx == 4));
                    if (out_last === 1'b1) done = 1'b1;
                    idx++;
                end
            end
            if (done) begin
                req_valid = 1'b0;
            end else begin
                req_valid  = ~req_valid;
                req_weight = 3'd3;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("w1 done", 32'(done), 1);
        checkOutput("w1 count", 32'(idx), 5);
        checkOutput("w1 idle req_ready", 32'(req_ready), 1);
        @(negedge clk);
        checkOutput("w1 nothing queued", 32'(out_valid), 0);
        checkOutput("w1 still idle", 32'(req_ready), 1);

        $display("[TB] weight 3 with throttled out_ready");
        applyStimulus(1'b1, 3'd3, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        idx = 0;
        done = 1'b0;
        stalled = 1'b0;
        held_pat = '0;
        held_last = 1'b0;
        prev_pat = '0;
        for (int c = 0; c < 600 && !done; c++) begin
            if (stalled) begin
                checkOutput("w3 hold valid", 32'(out_valid), 1);
                checkOutput("w3 hold pattern", 32'(out_pattern), 32'(held_pat));
                checkOutput("w3 hold last", 32'(out_last), 32'(held_last));
            end
            if (out_valid === 1'b1) begin
                held_pat  = out_pattern;
                held_last = out_last;
                out_ready = 1'($urandom_range(0, 1));
                stalled   = !out_ready;
                if (out_ready) begin
                    if (idx < 10) checkOutput("w3 pattern", 32'(out_pattern), 32'(exp_w3[idx]));
                    checkOutput("w3 popcount", 32'($countones(out_pattern)), 3);
                    if (idx > 0) checkOutput("w3 ascending", 32'(out_pattern > prev_pat), 1);
                    checkOutput("w3 last", 32'(out_last), 32'(idx == 9));
                    prev_pat = out_pattern;
                    idx++;
                    if (out_last === 1'b1 || idx >= 10) done = 1'b1;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
                stalled   = 1'b0;
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checkOutput("w3 done", 32'(done), 1);
        checkOutput("w3 count", 32'(idx), 10);
        checkOutput("w3 final pattern", 32'(prev_pat), 32'h1C);
        checkOutput("w3 idle req_ready", 32'(req_ready), 1);

        $display("[TB] weight 4 aborted by reset in EMIT");
        applyStimulus(1'b1, 3'd4, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        waitValid(got);
        checkOutput("w4 first valid", 32'(got), 1);
        checkOutput("w4 first pattern", 32'(out_pattern), 32'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 32'(out_valid), 0);
        checkOutput("abort out_pattern", 32'(out_pattern), 0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("abort req_ready", 32'(req_ready), 1);
        checkOutput("abort out_valid after", 32'(out_valid), 0);
        applyStimulus(1'b1, 3'd4, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            collectPattern("w4", exp_w4[i], i == 4);
        end
        checkOutput("w4 idle req_ready", 32'(req_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
